// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back/commit unit.
// Optional feature macro: WB_RETIRE_CNT_EN (adds a retired-instruction counter to wb_commit).
package wb_pkg;

    // Commit FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_e;

    // What an accepted instruction turns into.
    typedef enum logic [1:0] {
        ACC_RETIRE = 2'd0,  // retires immediately, no register write
        ACC_LOAD   = 2'd1,  // must wait for memory read data
        ACC_WRITE  = 2'd2   // write data already known
    } acc_kind_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Classify an incoming instruction from its resolved destination.
    // jal takes precedence over the load flag, so a jal is never treated as a load.
    function automatic acc_kind_e classify(input logic       reg_write,
                                           input logic       mem_to_reg,
                                           input logic       jal,
                                           input logic [4:0] dest);
        if (!reg_write || (dest == REG_ZERO)) begin
            return ACC_RETIRE;
        end else if (mem_to_reg && !jal) begin
            return ACC_LOAD;
        end else begin
            return ACC_WRITE;
        end
    endfunction

endpackage

// File: rtl/wb_commit_timeout_counter.sv
// Load-wait timeout counter: cleared when a load is accepted, counts while enabled,
// and flags expiry on the last allowed waiting cycle.
module wb_timeout_counter #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5      // 2**CNT_W must exceed MEM_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_reg;

    // Counter register; clear has priority over counting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/wb_commit.sv
// Write-back/commit unit: accepts completed instructions from execute, waits for
// load data when needed, and drives a single-cycle register-file write.
// Optional feature macro: WB_RETIRE_CNT_EN adds output retire_count[31:0].
module wb_commit
    import wb_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_alu_result,
    input  logic [4:0]  in_dest,
    input  logic        in_reg_write,
    input  logic        in_mem_to_reg,
    input  logic        in_jal,
    input  logic [31:0] in_pc_plus4,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pend_valid,
    output logic [4:0]  pend_dest,
    output logic        err_timeout
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_count
`endif
);

    wb_state_e   state_reg, state_next;
    logic [4:0]  dest_reg, dest_next;
    logic [31:0] data_reg, data_next;
    logic        err_timeout_reg, err_timeout_next;

    logic        accept;
    acc_kind_e   acc_kind;
    logic [4:0]  acc_dest;
    logic [31:0] acc_data;
    logic        cnt_clear;
    logic        cnt_enable;
    logic        cnt_expired;
    logic        timeout_hit;
    logic        write_active;

    // jal always targets $31 with PC+4; everything else uses the resolved dest and ALU result.
    assign acc_dest = in_jal ? REG_RA : in_dest;
    assign acc_data = in_jal ? in_pc_plus4 : in_alu_result;
    assign acc_kind = classify(in_reg_write, in_mem_to_reg, in_jal, acc_dest);

    // WRITE can accept too, so straight ALU traffic sustains one instruction per cycle.
    assign in_ready     = (state_reg == IDLE) || (state_reg == WRITE);
    assign accept       = in_valid && in_ready;
    assign write_active = (state_reg == WRITE);
    assign cnt_enable   = (state_reg == WAIT_MEM);

    wb_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus the updates for latched destination, data and error flag.
    always_comb begin
        state_next       = state_reg;
        dest_next        = dest_reg;
        data_next        = data_reg;
        err_timeout_next = err_timeout_reg;
        cnt_clear        = 1'b0;
        timeout_hit      = 1'b0;
        case (state_reg)
            IDLE, WRITE: begin
                state_next = IDLE;
                if (accept) begin
                    case (acc_kind)
                        ACC_LOAD: begin
                            state_next = WAIT_MEM;
                            dest_next  = acc_dest;
                            cnt_clear  = 1'b1;
                        end
                        ACC_WRITE: begin
                            state_next = WRITE;
                            dest_next  = acc_dest;
                            data_next  = acc_data;
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
            WAIT_MEM: begin
                // Data arriving on the expiry cycle still counts as a successful load.
                if (mem_rvalid) begin
                    data_next  = mem_rdata;
                    state_next = WRITE;
                end else if (cnt_expired) begin
                    timeout_hit      = 1'b1;
                    err_timeout_next = 1'b1;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latched destination, write data and sticky timeout flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dest_reg        <= REG_ZERO;
            data_reg        <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            dest_reg        <= dest_next;
            data_reg        <= data_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

    assign rf_we       = write_active;
    assign pend_valid  = (state_reg == WAIT_MEM) || (state_reg == WRITE);
    assign err_timeout = err_timeout_reg;

    // Write port and pending tag read as zero whenever they carry nothing meaningful.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_wdata
            assign rf_wdata[gi] = data_reg[gi] & write_active;
        end
        for (gi = 0; gi < 5; gi++) begin : g_dest
            assign rf_waddr[gi]  = dest_reg[gi] & write_active;
            assign pend_dest[gi] = dest_reg[gi] & pend_valid;
        end
    endgenerate

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count_reg;
    logic [1:0]  retire_inc;

    // A finishing write and a no-write acceptance can retire in the same cycle.
    assign retire_inc = {1'b0, write_active}
                      + {1'b0, (accept && (acc_kind == ACC_RETIRE))}
                      + {1'b0, timeout_hit};

    // Retired-instruction counter, wrapping naturally at 2**32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retire_count_reg <= '0;
        end else begin
            retire_count_reg <= retire_count_reg + 32'(retire_inc);
        end
    end

    assign retire_count = retire_count_reg;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed cases followed by randomized
// instructions, each checked against expectations derived from the commit rules.
module tb_wb_commit;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_alu_result = '0;
    logic [4:0]  in_dest = '0;
    logic        in_reg_write = 1'b0;
    logic        in_mem_to_reg = 1'b0;
    logic        in_jal = 1'b0;
    logic [31:0] in_pc_plus4 = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pend_valid;
    logic [4:0]  pend_dest;
    logic        err_timeout;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;
    int   exp_retire = 0;
    int   txn = 0;

    wb_commit #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_alu_result (in_alu_result),
        .in_dest       (in_dest),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_jal        (in_jal),
        .in_pc_plus4   (in_pc_plus4),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pend_valid    (pend_valid),
        .pend_dest     (pend_dest),
        .err_timeout   (err_timeout)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count  (retire_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_retire();
`ifdef WB_RETIRE_CNT_EN
        chk("retire_count", retire_count, 32'(exp_retire));
`endif
    endtask

    // One instruction from an idle unit. delay = WAIT_MEM cycle index on which
    // mem_rvalid is driven; delay >= TO means the memory never answers.
    task automatic issue(input logic [31:0] alu, input logic [4:0] dest, input logic rw,
                         input logic m2r, input logic jal, input logic [31:0] pc,
                         input int delay, input logic [31:0] rdata);
        logic [4:0]  exp_dest;
        logic [31:0] exp_data;
        logic        writes;
        logic        is_load;
        string       outcome;
        exp_dest = jal ? 5'd31 : dest;
        exp_data = jal ? pc : alu;
        writes   = rw && (exp_dest != 5'd0);
        is_load  = writes && m2r && !jal;

        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_pend", 32'(pend_valid), 32'd0);
        chk("err_sticky", 32'(err_timeout), 32'(exp_err));

        in_valid = 1'b1; in_alu_result = alu; in_dest = dest; in_reg_write = rw;
        in_mem_to_reg = m2r; in_jal = jal; in_pc_plus4 = pc;
        mem_rvalid = 1'($urandom_range(0, 1));   // must be ignored outside WAIT_MEM
        mem_rdata  = $urandom;
        @(negedge clock);
        in_valid = 1'b0; mem_rvalid = 1'b0;

        if (!writes) begin
            outcome = "nowrite";
            chk("nw_we", 32'(rf_we), 32'd0);
            chk("nw_pend", 32'(pend_valid), 32'd0);
            chk("nw_ready", 32'(in_ready), 32'd1);
        end else if (!is_load) begin
            outcome = "write";
            chk("w_we", 32'(rf_we), 32'd1);
            chk("w_waddr", 32'(rf_waddr), 32'(exp_dest));
            chk("w_wdata", rf_wdata, exp_data);
            chk("w_pend_dest", 32'(pend_dest), 32'(exp_dest));
            chk("w_ready", 32'(in_ready), 32'd1);
            mem_rvalid = 1'($urandom_range(0, 1));
            @(negedge clock);
            mem_rvalid = 1'b0;
            chk("w_we_drop", 32'(rf_we), 32'd0);
            chk("w_pend_drop", 32'(pend_valid), 32'd0);
        end else begin
            for (int k = 0; k < TO; k++) begin
                chk("ld_ready", 32'(in_ready), 32'd0);
                chk("ld_pend", 32'(pend_valid), 32'd1);
                chk("ld_pend_dest", 32'(pend_dest), 32'(exp_dest));
                chk("ld_we", 32'(rf_we), 32'd0);
                if (k == delay) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                end
                @(negedge clock);
                mem_rvalid = 1'b0;
                if (k == delay) break;
            end
            if (delay < TO) begin
                outcome = "load";
                chk("ld_wr_we", 32'(rf_we), 32'd1);
                chk("ld_wr_waddr", 32'(rf_waddr), 32'(exp_dest));
                chk("ld_wr_wdata", rf_wdata, rdata);
                @(negedge clock);
                chk("ld_we_drop", 32'(rf_we), 32'd0);
            end else begin
                outcome = "timeout";
                exp_err = 1'b1;
                chk("to_err", 32'(err_timeout), 32'd1);
                chk("to_we", 32'(rf_we), 32'd0);
                chk("to_ready", 32'(in_ready), 32'd1);
                chk("to_pend", 32'(pend_valid), 32'd0);
            end
        end
        exp_retire++;
        chk_retire();
        txn++;
        $display("txn %0d issue dest=%0d rw=%0d ld=%0d jal=%0d delay=%0d -> %s retired=%0d",
                 txn, dest, rw, m2r, jal, delay, outcome, exp_retire);
    endtask

    // Continuous ALU/jal traffic, one acceptance per cycle.
    task automatic stream(input int n);
        logic [31:0] alu, pc, ev;
        logic [4:0]  d, ed;
        logic        rw, j, w;
        for (int i = 0; i < n; i++) begin
            alu = $urandom; pc = $urandom;
            d   = 5'($urandom_range(0, 31));
            rw  = ($urandom_range(0, 3) != 0);
            j   = ($urandom_range(0, 3) == 0);
            in_valid = 1'b1; in_alu_result = alu; in_dest = d; in_reg_write = rw;
            in_mem_to_reg = 1'b0; in_jal = j; in_pc_plus4 = pc;
            mem_rvalid = 1'($urandom_range(0, 1));
            @(negedge clock);
            ed = j ? 5'd31 : d;
            ev = j ? pc : alu;
            w  = rw && (ed != 5'd0);
            chk("st_ready", 32'(in_ready), 32'd1);
            chk("st_we", 32'(rf_we), 32'(w));
            if (w) begin
                chk("st_waddr", 32'(rf_waddr), 32'(ed));
                chk("st_wdata", rf_wdata, ev);
            end
            exp_retire++;
            txn++;
            $display("txn %0d stream dest=%0d rw=%0d jal=%0d write=%0d", txn, ed, rw, j, w);
        end
        in_valid = 1'b0; mem_rvalid = 1'b0;
        @(negedge clock);
        chk("st_end_we", 32'(rf_we), 32'd0);
        chk_retire();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_pend", 32'(pend_valid), 32'd0);
        chk("rst_pend_dest", 32'(pend_dest), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk_retire();
        reset = 1'b1;
        @(negedge clock);

        // Directed cases
        issue(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 0, 32'h0);
        issue(32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0, 3, 32'hDEAD_BEEF);
        issue(32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 0, 32'h0);
        issue(32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0, TO - 1, 32'hCAFE_F00D);  // data on expiry cycle wins
        issue(32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 2, 32'h1111_1111);       // load to $0 retires
        issue(32'h55, 5'd4, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 0, 32'h0);      // jal without reg_write
        issue(32'h66, 5'd4, 1'b1, 1'b1, 1'b1, 32'h0000_00C0, 0, 32'h0);      // jal beats load flag

        // Back-to-back: dest 3 then dest 0
        in_valid = 1'b1; in_alu_result = 32'hA5A5_0003; in_dest = 5'd3; in_reg_write = 1'b1;
        in_mem_to_reg = 1'b0; in_jal = 1'b0;
        @(negedge clock);
        chk("b2b_we1", 32'(rf_we), 32'd1);
        chk("b2b_waddr1", 32'(rf_waddr), 32'd3);
        chk("b2b_wdata1", rf_wdata, 32'hA5A5_0003);
        chk("b2b_ready1", 32'(in_ready), 32'd1);
        in_alu_result = 32'h0BAD_0000; in_dest = 5'd0;
        @(negedge clock);
        in_valid = 1'b0;
        chk("b2b_we2", 32'(rf_we), 32'd0);
        chk("b2b_ready2", 32'(in_ready), 32'd1);
        @(negedge clock);
        chk("b2b_we3", 32'(rf_we), 32'd0);
        exp_retire += 2;
        chk_retire();
        txn++;
        $display("txn %0d back-to-back dest 3 then dest 0 retired=%0d", txn, exp_retire);

        // Timeout, then confirm the flag is sticky on the next instruction
        issue(32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 32'h0, TO, 32'h0);
        issue(32'h77, 5'd11, 1'b1, 1'b0, 1'b0, 32'h0, 0, 32'h0);

        // Randomized instructions
        for (int i = 0; i < 40; i++) begin
            issue($urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom,
                  $urandom_range(0, TO + 1), $urandom);
        end
        stream(30);

        // Reset in the middle of WAIT_MEM, then a stray rvalid
        in_valid = 1'b1; in_dest = 5'd12; in_reg_write = 1'b1; in_mem_to_reg = 1'b1; in_jal = 1'b0;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        chk("mid_pend", 32'(pend_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_we", 32'(rf_we), 32'd0);
        chk("mr_pend", 32'(pend_valid), 32'd0);
        chk("mr_err", 32'(err_timeout), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clock);
        mem_rvalid = 1'b0;
        chk("mr_we2", 32'(rf_we), 32'd0);
        chk("mr_waddr", 32'(rf_waddr), 32'd0);
        chk("mr_wdata", rf_wdata, 32'd0);
        chk("mr_pend_dest", 32'(pend_dest), 32'd0);
        reset = 1'b1;
        exp_err = 1'b0;
        exp_retire = 0;
        @(negedge clock);
        mem_rvalid = 1'b1;
        @(negedge clock);
        mem_rvalid = 1'b0;
        chk("mr_after_we", 32'(rf_we), 32'd0);
        chk("mr_after_pend", 32'(pend_valid), 32'd0);
        chk_retire();
        txn++;
        $display("txn %0d reset during WAIT_MEM dropped", txn);

        // Unit still works after the reset
        issue(32'h0000_BEEF, 5'd20, 1'b1, 1'b0, 1'b0, 32'h0, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
